// File: rtl/bank_ctr_readout.sv
// Snapshot-and-stream readout of the bank-counter array: captures all N signed counters on start,
// then emits one ReLU/saturated value per valid/ready beat.
module bank_ctr_readout #(
   parameter int N_S   = 4,
   parameter int N_C   = 8,
   parameter int BCP   = 10,
   parameter int OUT_W = 8,
   parameter int IDX_W = (N_S * N_C > 1) ? $clog2(N_S * N_C) : 1
) (
   input  logic                     CLK,
   input  logic                     RESET_N,
   input  logic [N_S*N_C*BCP-1:0]   ctr_in,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     relu_en,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OUT_W-1:0]         out_data,
   output logic [IDX_W-1:0]         out_idx,
   output logic                     out_last,
   output logic                     out_sat,
   output logic                     busy,
   output logic                     done,
   output logic                     sat_seen
);

   localparam int N = N_S * N_C;
   localparam logic signed [BCP-1:0] SAT_HI = BCP'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [BCP-1:0] SAT_LO = BCP'(-(1 << (OUT_W - 1)));
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t             state_q;
   logic [BCP-1:0]     snap_q [N];
   logic [BCP-1:0]     ctr_el [N];
   logic [IDX_W-1:0]   idx_q;
   logic [IDX_W-1:0]   idx_d;
   logic               relu_q;
   logic               valid_q;
   logic [OUT_W-1:0]   data_q;
   logic               sat_q;
   logic               last_q;
   logic               done_q;
   logic               sat_seen_q;

   // Returns {sat, data}.
   function automatic logic [OUT_W:0] xform(input logic signed [BCP-1:0] v_in, input logic relu);
      logic signed [BCP-1:0] v;
      v = (relu && v_in[BCP-1]) ? '0 : v_in;
      if (v > SAT_HI)
         return {1'b1, SAT_HI[OUT_W-1:0]};
      else if (v < SAT_LO)
         return {1'b1, SAT_LO[OUT_W-1:0]};
      else
         return {1'b0, v[OUT_W-1:0]};
   endfunction

   always_comb begin
      for (int unsigned i = 0; i < N; i++)
         ctr_el[i] = ctr_in[i*BCP +: BCP];
   end

   assign idx_d = idx_q + 1'b1;

   // Output registers are loaded from the element about to be presented, so beats run back-to-back.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= S_IDLE;
         for (int unsigned i = 0; i < N; i++)
            snap_q[i] <= '0;
         idx_q      <= '0;
         relu_q     <= 1'b0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         sat_q      <= 1'b0;
         last_q     <= 1'b0;
         done_q     <= 1'b0;
         sat_seen_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start && !abort) begin
                  snap_q           <= ctr_el;
                  relu_q           <= relu_en;
                  idx_q            <= '0;
                  sat_seen_q       <= 1'b0;
                  {sat_q, data_q}  <= xform(ctr_el[0], relu_en);
                  last_q           <= (N == 1);
                  valid_q          <= 1'b1;
                  state_q          <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (abort) begin
                  valid_q <= 1'b0;
                  state_q <= S_IDLE;
               end else if (out_ready) begin
                  sat_seen_q <= sat_seen_q | sat_q;
                  if (idx_q == IDX_LAST) begin
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     idx_q           <= idx_d;
                     {sat_q, data_q} <= xform(snap_q[idx_d], relu_q);
                     last_q          <= (idx_d == IDX_LAST);
                  end
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_idx   = idx_q;
   assign out_last  = last_q;
   assign out_sat   = sat_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign sat_seen  = sat_seen_q;

endmodule

// File: tb/tb_bank_ctr_readout.sv
// Directed bench for bank_ctr_readout: scans, saturation, ReLU, snapshot isolation, backpressure,
// abort/start races and asynchronous reset.
module tb_bank_ctr_readout;

   localparam int N_S   = 4;
   localparam int N_C   = 8;
   localparam int N     = N_S * N_C;
   localparam int BCP   = 10;
   localparam int OUT_W = 8;
   localparam int IDX_W = 5;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [N*BCP-1:0]     ctr_in = '0;
   logic                 start = 1'b0;
   logic                 abort = 1'b0;
   logic                 relu_en = 1'b0;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic [OUT_W-1:0]     out_data;
   logic [IDX_W-1:0]     out_idx;
   logic                 out_last;
   logic                 out_sat;
   logic                 busy;
   logic                 done;
   logic                 sat_seen;

   int n_asserts = 0;
   int n_fail    = 0;
   int exp_v [N];

   bank_ctr_readout #(.N_S(N_S), .N_C(N_C), .BCP(BCP), .OUT_W(OUT_W), .IDX_W(IDX_W)) dut (
      .CLK(clk), .RESET_N(rst_n), .ctr_in(ctr_in), .start(start), .abort(abort),
      .relu_en(relu_en), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx), .out_last(out_last), .out_sat(out_sat), .busy(busy), .done(done),
      .sat_seen(sat_seen)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic set_el(input int k, input int v);
      logic [BCP-1:0] tmp;
      tmp = BCP'(v);
      ctr_in[k*BCP +: BCP] = tmp;
   endtask

   task automatic load(input int k, input int v);
      set_el(k, v);
      exp_v[k] = v;
   endtask

   function automatic int exp_xf(input int v_in, input bit relu, output bit s);
      int v;
      int hi;
      int lo;
      hi = (1 << (OUT_W - 1)) - 1;
      lo = -(1 << (OUT_W - 1));
      v  = (relu && v_in < 0) ? 0 : v_in;
      s  = 1'b0;
      if (v > hi) begin
         s = 1'b1;
         v = hi;
      end else if (v < lo) begin
         s = 1'b1;
         v = lo;
      end
      return v & ((1 << OUT_W) - 1);
   endfunction

   task automatic run_scan(input bit relu, input int rdy_pct, input bit chg,
                           input int restart_k, input int abort_k, input bit start_in_done);
      int  k;
      int  budget;
      int  d;
      bit  s;
      bit  rdy;
      bit  sat_any;
      k = 0;
      budget = 0;
      sat_any = 1'b0;
      @(negedge clk);
      relu_en = relu;
      start = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      relu_en = ~relu;
      if (chg)
         for (int i = 0; i < N; i++) set_el(i, 1);
      check_eq("busy_scan", busy, 1);
      while (k < N && budget < 2000) begin
         budget++;
         check_eq("valid", out_valid, 1);
         if (!out_valid) break;
         d = exp_xf(exp_v[k], relu, s);
         check_eq("idx", out_idx, k);
         check_eq("data", out_data, d);
         check_eq("sat", out_sat, s);
         check_eq("last", out_last, (k == N - 1));
         rdy = (rdy_pct >= 100) || ($urandom_range(0, 99) < rdy_pct);
         if (k == restart_k || k == abort_k) rdy = 1'b1;
         out_ready = rdy;
         start = (k == restart_k);
         abort = (k == abort_k);
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         if (k == abort_k) begin
            out_ready = 1'b0;
            check_eq("abort_valid", out_valid, 0);
            check_eq("abort_busy", busy, 0);
            check_eq("abort_done", done, 0);
            check_eq("abort_sat_seen", sat_seen, sat_any);
            @(negedge clk);
            check_eq("abort_done2", done, 0);
            check_eq("abort_busy2", busy, 0);
            return;
         end
         if (rdy) begin
            sat_any |= s;
            k++;
         end
      end
      out_ready = 1'b0;
      check_eq("beats", k, N);
      check_eq("done", done, 1);
      check_eq("done_valid", out_valid, 0);
      check_eq("sat_seen", sat_seen, sat_any);
      start = start_in_done;
      @(negedge clk);
      start = 1'b0;
      check_eq("done_pulse", done, 0);
      check_eq("idle_busy", busy, 0);
      if (start_in_done) begin
         @(negedge clk);
         check_eq("done_start_ignored", busy, 0);
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) exp_v[i] = 0;
      #1;
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_sat_seen", sat_seen, 0);
      check_eq("rst_data", out_data, 0);
      check_eq("rst_idx", out_idx, 0);
      check_eq("rst_last", out_last, 0);
      check_eq("rst_sat", out_sat, 0);
      #12 rst_n = 1'b1;

      // basic scan, with a start arriving in DONE
      for (int i = 0; i < N; i++) load(i, i - 16);
      run_scan(1'b0, 100, 1'b0, -1, -1, 1'b1);

      // saturation boundaries
      for (int i = 0; i < N; i++) load(i, i);
      load(0, 300); load(1, -300); load(2, 127); load(3, -128);
      load(4, 128); load(5, -129); load(6, 511); load(7, -512);
      run_scan(1'b0, 100, 1'b0, -1, -1, 1'b0);

      // ReLU plus snapshot isolation
      for (int i = 0; i < N; i++) load(i, i - 16);
      load(5, -7);
      run_scan(1'b1, 100, 1'b1, -1, -1, 1'b0);

      // backpressure
      for (int i = 0; i < N; i++) load(i, ((i * 37) % 1024) - 512);
      run_scan(1'b0, 30, 1'b0, -1, -1, 1'b0);

      // start during scan is ignored
      for (int i = 0; i < N; i++) load(i, 3 * i - 40);
      run_scan(1'b0, 100, 1'b0, 3, -1, 1'b0);

      // abort at idx 10; only beat 10 would saturate, so sat_seen stays 0
      for (int i = 0; i < N; i++) load(i, i);
      load(10, 400);
      run_scan(1'b0, 100, 1'b0, -1, 10, 1'b0);

      // start and abort together in IDLE
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check_eq("race_busy", busy, 0);
      check_eq("race_valid", out_valid, 0);

      // asynchronous reset mid-scan
      for (int i = 0; i < N; i++) load(i, i);
      load(0, 300);
      @(negedge clk);
      start = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("pre_rst_busy", busy, 1);
      check_eq("pre_rst_sat_seen", sat_seen, 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_valid", out_valid, 0);
      check_eq("arst_busy", busy, 0);
      check_eq("arst_done", done, 0);
      check_eq("arst_sat_seen", sat_seen, 0);
      check_eq("arst_idx", out_idx, 0);
      out_ready = 1'b0;
      #10 rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
